uart_tx_fifo: RTL and testbench

//  Synchronous byte FIFO directly upstream of the UART serializer; buffers bytes from the

---
 rtl/uart_tx_fifo_pkg.sv | 12 +
 rtl/uart_tx_fifo_if.sv | 37 +++
 rtl/uart_fifo_ram.sv | 34 +++
 rtl/uart_tx_fifo.sv | 98 +++++++++
 tb/tb_uart_tx_fifo.sv | 146 ++++++++++++++
 5 files changed

// File: rtl/uart_tx_fifo_pkg.sv
// Shared UART definitions used by the TX FIFO, serializer and deserializer.
//   UART_DATA_W : default byte width on the UART data path
//   is_pow2()   : elaboration-time helper for power-of-two parameter checks
package uart_pkg;

  localparam int unsigned UART_DATA_W = 8;

  function automatic bit is_pow2(input int unsigned v);
    return (v != 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Handshake bundle between the system writer / UART serializer and the TX FIFO.
//   master : system write side and serializer read side (drives requests and write data)
//   slave  : the FIFO (drives flags, occupancy and read data)
// Signals:
//   wr_en_i, wr_data_i            write request and data
//   full_o                        FIFO full
//   fifo_rd_en_i                  read request from serializer
//   fifo_rd_data_o                registered read data, valid 1 clk after accepted read
//   fifo_empty_o                  FIFO empty
//   count_o                       occupancy 0..DEPTH
interface uart_tx_fifo_if
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned DATA_W = UART_DATA_W
);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic              wr_en_i;
  logic [DATA_W-1:0] wr_data_i;
  logic              full_o;
  logic              fifo_rd_en_i;
  logic [DATA_W-1:0] fifo_rd_data_o;
  logic              fifo_empty_o;
  logic [CNT_W-1:0]  count_o;

  modport master (
    output wr_en_i, wr_data_i, fifo_rd_en_i,
    input  full_o, fifo_rd_data_o, fifo_empty_o, count_o
  );

  modport slave (
    input  wr_en_i, wr_data_i, fifo_rd_en_i,
    output full_o, fifo_rd_data_o, fifo_empty_o, count_o
  );

endinterface

// File: rtl/uart_fifo_ram.sv
// Simple dual-port RAM for the UART TX FIFO: one write port, one registered read port.
// Storage is never reset; only the read register is (so read data comes up as 0).
// Ports:
//   clk, rst          clock, synchronous active-high reset (read register only)
//   we, wr_addr, wr_data    write port
//   rd_en, rd_addr    read request; rd_data updates on the next clock
//   rd_data           registered read data, holds when rd_en is low
module uart_fifo_ram #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst)        rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO feeding the UART serializer. No fall-through: a byte
// written at cycle N can be read at N+1 at the earliest, with data at N+2.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   bus        uart_tx_fifo_if.slave (write side, serializer read side, flags, count)
//   ovf_o      sticky overflow  (only with UART_FIFO_ERR_FLAGS_EN defined)
//   udf_o      sticky underflow (only with UART_FIFO_ERR_FLAGS_EN defined)
// Configuration macro: UART_FIFO_ERR_FLAGS_EN
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned DATA_W = UART_DATA_W
) (
  input  logic clk,
  input  logic rst,
  uart_tx_fifo_if.slave bus
`ifdef UART_FIFO_ERR_FLAGS_EN
  ,
  output logic ovf_o,
  output logic udf_o
`endif
);

  localparam int unsigned ADDR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W  = ADDR_W + 1;

  if (DEPTH < 2 || !is_pow2(DEPTH)) begin : g_depth_check
    $error("uart_tx_fifo: DEPTH must be a power of 2 and >= 2");
  end

  logic [ADDR_W-1:0] wr_ptr_q;
  logic [ADDR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  count_nxt;
  logic              full_q;
  logic              empty_q;
  logic              wr_acc;
  logic              rd_acc;
  logic [DATA_W-1:0] rd_data;

  // Acceptance uses the registered flags, so a write while full is dropped
  // even if a read frees a slot in the same cycle, and vice versa.
  always_comb begin
    wr_acc    = bus.wr_en_i & ~full_q;
    rd_acc    = bus.fifo_rd_en_i & ~empty_q;
    count_nxt = count_q + CNT_W'(wr_acc) - CNT_W'(rd_acc);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (wr_acc) wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
      if (rd_acc) rd_ptr_q <= rd_ptr_q + ADDR_W'(1);
      count_q <= count_nxt;
      full_q  <= (count_nxt == CNT_W'(DEPTH));
      empty_q <= (count_nxt == '0);
    end
  end

  uart_fifo_ram #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .we      (wr_acc),
    .wr_addr (wr_ptr_q),
    .wr_data (bus.wr_data_i),
    .rd_en   (rd_acc),
    .rd_addr (rd_ptr_q),
    .rd_data (rd_data)
  );

  assign bus.fifo_rd_data_o = rd_data;
  assign bus.full_o         = full_q;
  assign bus.fifo_empty_o   = empty_q;
  assign bus.count_o        = count_q;

`ifdef UART_FIFO_ERR_FLAGS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_o <= 1'b0;
      udf_o <= 1'b0;
    end else begin
      if (bus.wr_en_i & full_q)       ovf_o <= 1'b1;
      if (bus.fifo_rd_en_i & empty_q) udf_o <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo against a queue-based reference model.
module tb_uart_tx_fifo;
  import uart_pkg::*;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned DW    = UART_DATA_W;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

`ifdef UART_FIFO_ERR_FLAGS_EN
  logic ovf, udf;
`endif

  uart_tx_fifo_if #(.DEPTH(DEPTH), .DATA_W(DW)) bus ();

  uart_tx_fifo #(.DEPTH(DEPTH), .DATA_W(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
`ifdef UART_FIFO_ERR_FLAGS_EN
    ,
    .ovf_o (ovf),
    .udf_o (udf)
`endif
  );

  int tests = 0;
  int fails = 0;

  // Reference model
  logic [DW-1:0] q[$];
  logic [DW-1:0] m_data = '0;
  bit            m_ovf  = 1'b0;
  bit            m_udf  = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".count"}, 32'(bus.count_o), 32'(q.size()));
    chk({tag, ".empty"}, 32'(bus.fifo_empty_o), 32'(q.size() == 0));
    chk({tag, ".full"}, 32'(bus.full_o), 32'(q.size() == DEPTH));
    chk({tag, ".data"}, 32'(bus.fifo_rd_data_o), 32'(m_data));
`ifdef UART_FIFO_ERR_FLAGS_EN
    chk({tag, ".ovf"}, 32'(ovf), 32'(m_ovf));
    chk({tag, ".udf"}, 32'(udf), 32'(m_udf));
`endif
  endtask

  // One clock: drive inputs, advance model at the edge, compare 1 ns later.
  task automatic step(input string tag, input logic r, input logic w,
                      input logic [DW-1:0] d, input logic rd);
    bit sz_full, sz_empty;
    rst              = r;
    bus.wr_en_i      = w;
    bus.wr_data_i    = d;
    bus.fifo_rd_en_i = rd;
    @(posedge clk);
    if (r) begin
      q.delete();
      m_data = '0;
      m_ovf  = 1'b0;
      m_udf  = 1'b0;
    end else begin
      sz_full  = (q.size() == DEPTH);
      sz_empty = (q.size() == 0);
      if (w && sz_full)   m_ovf = 1'b1;
      if (rd && sz_empty) m_udf = 1'b1;
      if (rd && !sz_empty) m_data = q.pop_front();
      if (w && !sz_full)   q.push_back(d);
    end
    #1;
    check_all(tag);
  endtask

  initial begin
    logic [DW-1:0] expv;
    rst = 1'b1;
    bus.wr_en_i = 1'b0;
    bus.wr_data_i = '0;
    bus.fifo_rd_en_i = 1'b0;

    // 1: reset held for two clocks
    step("rst0", 1'b1, 1'b0, '0, 1'b0);
    step("rst1", 1'b1, 1'b0, '0, 1'b0);
    chk("rst.empty_const", 32'(bus.fifo_empty_o), 32'd1);

    // 2: single byte latency
    step("wr_a5", 1'b0, 1'b1, 8'hA5, 1'b0);
    chk("wr_a5.not_empty", 32'(bus.fifo_empty_o), 32'd0);
    step("rd_a5", 1'b0, 1'b0, '0, 1'b1);
    chk("rd_a5.value", 32'(bus.fifo_rd_data_o), 32'hA5);

    // 3: fill, overflow attempt, drain in order
    for (int i = 0; i < 16; i++) step("fill", 1'b0, 1'b1, DW'(i), 1'b0);
    chk("fill.full", 32'(bus.full_o), 32'd1);
    step("ovf_wr", 1'b0, 1'b1, 8'hFF, 1'b0);
    step("ovf_wr_rd", 1'b0, 1'b1, 8'hEE, 1'b1);
    step("refill", 1'b0, 1'b0, '0, 1'b0);
    for (int i = 0; i < 16; i++) begin
      step("drain", 1'b0, 1'b0, '0, 1'b1);
      expv = (i == 0) ? 8'h00 : DW'(i);
    end
    while (q.size() != 0) step("drain_rest", 1'b0, 1'b0, '0, 1'b1);
    chk("drain.empty", 32'(bus.fifo_empty_o), 32'd1);

    // 4: wrap with simultaneous traffic at occupancy 8
    for (int i = 0; i < 8; i++) step("pre8", 1'b0, 1'b1, DW'($urandom), 1'b0);
    for (int i = 0; i < 24; i++) begin
      step("wrap", 1'b0, 1'b1, DW'($urandom), 1'b1);
      chk("wrap.count8", 32'(bus.count_o), 32'd8);
    end
    for (int i = 0; i < 8; i++) step("wrap_drain", 1'b0, 1'b0, '0, 1'b1);

    // 5: empty with simultaneous write and read
    expv = bus.fifo_rd_data_o;
    step("empty_wr_rd", 1'b0, 1'b1, 8'h3C, 1'b1);
    chk("empty_wr_rd.count1", 32'(bus.count_o), 32'd1);
    chk("empty_wr_rd.hold", 32'(bus.fifo_rd_data_o), 32'(expv));
    step("empty_wr_rd_get", 1'b0, 1'b0, '0, 1'b1);

    // 6: reset with contents discards them
    for (int i = 0; i < 5; i++) step("pre5", 1'b0, 1'b1, DW'(8'h50 + i), 1'b0);
    step("mid_rst", 1'b1, 1'b0, '0, 1'b0);
    step("post_wr", 1'b0, 1'b1, 8'h77, 1'b0);
    step("post_rd", 1'b0, 1'b0, '0, 1'b1);
    chk("post_rd.value", 32'(bus.fifo_rd_data_o), 32'h77);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      step("rand", ($urandom_range(0, 99) == 0), ($urandom_range(0, 99) < 55),
           DW'($urandom), ($urandom_range(0, 99) < 50));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
